frame_compositor: RTL and testbench

Downstream of the scrolling-background stage. Merges the Mario sprite colour, the background colour and the sky gradient into the final VGA RGB stream. Aligns the combinational position and flag inputs with the one-cycle-late frame-RAM colour data. Runs the death fade sequence (fade out, hold black, fade in) and issues dead_reset to the background and Mario stages at the midpoint.

---
 rtl/frame_compositor.sv | 160 ++++++++++++++++
 tb/tb_frame_compositor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_compositor.sv
// Final pixel stage: aligns position/flags with late frame-RAM colour, selects sprite/background/sky,
// applies the death-sequence fade and issues dead_reset at the black midpoint.
module frame_compositor #(
    parameter int unsigned BG_LAT      = 1,
    parameter logic [23:0] KEY_COLOR   = 24'h800080,
    parameter int unsigned FADE_FRAMES = 4,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic       is_BG,
    input  logic       is_mario,
    input  logic [7:0] BG_Red,
    input  logic [7:0] BG_Green,
    input  logic [7:0] BG_Blue,
    input  logic [7:0] Mario_Red,
    input  logic [7:0] Mario_Green,
    input  logic [7:0] Mario_Blue,
    input  logic       dead,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       pixel_valid,
    output logic       dead_reset,
    output logic       fade_busy
);

    typedef enum logic [1:0] {PLAY, FADE_OUT, HOLD, FADE_IN} state_t;

    // Only DrawX[9:3] feeds the sky gradient; the row and sub-column bits are not needed here.
    logic pos_unused;
    assign pos_unused = ^{DrawY, DrawX[2:0]};

    // Pipe word: {DrawX[9:3], blank, is_BG, is_mario}
    logic [9:0] pipe_q [BG_LAT];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < BG_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {DrawX[9:3], blank, is_BG, is_mario};
            for (int unsigned i = 1; i < BG_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    logic [6:0] a_xhi;
    logic       a_blank, a_bg, a_mario;
    assign {a_xhi, a_blank, a_bg, a_mario} = pipe_q[BG_LAT-1];

    logic   frame_clk_q, tick;
    state_t state_q;
    logic [3:0] fade_lvl_q;
    logic [7:0] cnt_q;
    logic       dead_reset_q, fade_busy_q;

    assign tick = frame_clk & ~frame_clk_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_clk_q  <= 1'b0;
            state_q      <= PLAY;
            fade_lvl_q   <= '0;
            cnt_q        <= '0;
            dead_reset_q <= 1'b0;
            fade_busy_q  <= 1'b0;
        end else begin
            frame_clk_q  <= frame_clk;
            dead_reset_q <= 1'b0;
            case (state_q)
                PLAY: begin
                    if (dead) begin
                        state_q     <= FADE_OUT;
                        cnt_q       <= '0;
                        fade_busy_q <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (tick) begin
                        if (cnt_q == 8'(FADE_FRAMES - 1)) begin
                            cnt_q      <= '0;
                            fade_lvl_q <= fade_lvl_q + 4'd1;
                            if (fade_lvl_q == 4'd7) state_q <= HOLD;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (cnt_q == 8'(HOLD_FRAMES - 1)) begin
                            state_q      <= FADE_IN;
                            cnt_q        <= '0;
                            dead_reset_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                FADE_IN: begin
                    if (tick) begin
                        if (cnt_q == 8'(FADE_FRAMES - 1)) begin
                            cnt_q      <= '0;
                            fade_lvl_q <= fade_lvl_q - 4'd1;
                            if (fade_lvl_q == 4'd1) begin
                                state_q     <= PLAY;
                                fade_busy_q <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= PLAY;
                    fade_busy_q <= 1'b0;
                end
            endcase
        end
    end

    logic [23:0] sel_rgb;
    logic [7:0]  sh_r, sh_g, sh_b;

    always_comb begin
        sel_rgb = '0;
        if (!a_blank)
            sel_rgb = '0;
        else if (a_mario && ({Mario_Red, Mario_Green, Mario_Blue} != KEY_COLOR))
            sel_rgb = {Mario_Red, Mario_Green, Mario_Blue};
        else if (a_bg)
            sel_rgb = {BG_Red, BG_Green, BG_Blue};
        else
            sel_rgb = {16'h0000, 8'h7f - {1'b0, a_xhi}};
        sh_r = sel_rgb[23:16] >> fade_lvl_q;
        sh_g = sel_rgb[15:8]  >> fade_lvl_q;
        sh_b = sel_rgb[7:0]   >> fade_lvl_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            pixel_valid <= 1'b0;
        end else begin
            VGA_R       <= sh_r;
            VGA_G       <= sh_g;
            VGA_B       <= sh_b;
            pixel_valid <= a_blank;
        end
    end

    assign dead_reset = dead_reset_q;
    assign fade_busy  = fade_busy_q;

endmodule

// File: tb/tb_frame_compositor.sv
// Randomised scoreboard bench for frame_compositor: a tick-count model of the death sequence
// and a one-pixel-late colour pairing predict every registered output cycle.
module tb_frame_compositor;

    logic       Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic       blank = 1'b0, is_BG = 1'b0, is_mario = 1'b0, dead = 1'b0;
    logic [7:0] BG_Red = '0, BG_Green = '0, BG_Blue = '0;
    logic [7:0] Mario_Red = '0, Mario_Green = '0, Mario_Blue = '0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       pixel_valid, dead_reset, fade_busy;

    frame_compositor #(.BG_LAT(1), .KEY_COLOR(24'h800080), .FADE_FRAMES(4), .HOLD_FRAMES(30)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .is_BG(is_BG), .is_mario(is_mario),
        .BG_Red(BG_Red), .BG_Green(BG_Green), .BG_Blue(BG_Blue),
        .Mario_Red(Mario_Red), .Mario_Green(Mario_Green), .Mario_Blue(Mario_Blue),
        .dead(dead), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .pixel_valid(pixel_valid), .dead_reset(dead_reset), .fade_busy(fade_busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [23:0] rgb;
        logic        pv;
        logic        dr;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Model state
    bit rst_req = 1'b0;
    int px = 0;
    bit pb = 0, pbg = 0, pm = 0;
    bit prev_fc = 0;
    bit active = 0;
    int n = 0;
    int cyc = 0;
    int dr_seen = 0;

    // Death sequence as a function of ticks since dead: 32 out, 30 black, 32 in.
    function automatic int lvl_of(input int k);
        if (k < 32) return k / 4;
        if (k < 62) return 8;
        return 8 - (k - 62) / 4;
    endfunction

    function automatic logic [7:0] shade(input logic [7:0] c, input int l);
        return 8'(int'(c) / (1 << l));
    endfunction

    task automatic step(input int x, input bit b, input bit bg, input bit m,
                        input logic [23:0] bgc, input logic [23:0] mc,
                        input bit fc, input bit dd);
        exp_t        e;
        logic [23:0] rgb;
        int          l;
        bit          tk;
        @(negedge Clk);
        cyc++;
        Reset_n   = rst_req;
        DrawX     = 10'(x);
        DrawY     = 10'($urandom);
        blank     = b;
        is_BG     = bg;
        is_mario  = m;
        {BG_Red, BG_Green, BG_Blue}          = bgc;
        {Mario_Red, Mario_Green, Mario_Blue} = mc;
        frame_clk = fc;
        dead      = dd;
        if (!rst_req) begin
            e.rgb = '0; e.pv = 1'b0; e.dr = 1'b0; e.busy = 1'b0;
            q.push_back(e);
            px = 0; pb = 0; pbg = 0; pm = 0;
            prev_fc = 0; active = 0; n = 0;
        end else begin
            l = active ? lvl_of(n) : 0;
            if (!pb)                          rgb = '0;
            else if (pm && mc != 24'h800080)  rgb = mc;
            else if (pbg)                     rgb = bgc;
            else                              rgb = {16'h0000, 8'(127 - px / 8)};
            e.rgb = {shade(rgb[23:16], l), shade(rgb[15:8], l), shade(rgb[7:0], l)};
            e.pv  = pb;
            e.dr  = 1'b0;
            tk = fc && !prev_fc;
            prev_fc = fc;
            if (!active) begin
                if (dd) begin active = 1; n = 0; end
            end else if (tk) begin
                n++;
                if (n == 62) e.dr = 1'b1;
                if (n == 94) begin active = 0; n = 0; end
            end
            e.busy = active;
            q.push_back(e);
            px = x; pb = b; pbg = bg; pm = m;
        end
    endtask

    task automatic rstep(input logic [23:0] bgc, input logic [23:0] mc, input bit fc, input bit dd);
        step($urandom_range(0, 1023), 1'($urandom), 1'($urandom), 1'($urandom), bgc, mc, fc, dd);
    endtask

    function automatic logic [23:0] rnd_mario();
        return ($urandom_range(0, 3) == 0) ? 24'h800080 : 24'($urandom);
    endfunction

    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (dead_reset === 1'b1) dr_seen++;
            total++;
            if ({VGA_R, VGA_G, VGA_B} !== e.rgb) begin
                bad++;
                $display("FAIL rgb t=%0t got=%h exp=%h", $time, {VGA_R, VGA_G, VGA_B}, e.rgb);
            end
            total++;
            if (pixel_valid !== e.pv) begin
                bad++;
                $display("FAIL pixel_valid t=%0t got=%b exp=%b", $time, pixel_valid, e.pv);
            end
            total++;
            if (dead_reset !== e.dr) begin
                bad++;
                $display("FAIL dead_reset t=%0t got=%b exp=%b", $time, dead_reset, e.dr);
            end
            total++;
            if (fade_busy !== e.busy) begin
                bad++;
                $display("FAIL fade_busy t=%0t got=%b exp=%b", $time, fade_busy, e.busy);
            end
        end
    end

    initial begin
        int exp_dr;
        // Reset held with inputs toggling
        rst_req = 0;
        for (int i = 0; i < 6; i++) rstep(24'($urandom), rnd_mario(), 1'($urandom), 1'($urandom));
        rst_req = 1;
        for (int i = 0; i < 3; i++) rstep(24'($urandom), rnd_mario(), 1'b0, 1'b0);

        // Directed pixels: each pixel's colour arrives with the following step
        step(100, 1, 1, 0, 24'h123456, 24'h654321, 0, 0);
        rstep(24'hFEFEFE, 24'h0, 0, 0);
        step(200, 1, 1, 1, 24'h0, 24'h0, 0, 0);
        rstep(24'hE75A10, 24'h800080, 0, 0);
        step(200, 1, 1, 1, 24'h0, 24'h0, 0, 0);
        rstep(24'hE75A10, 24'hFEFEFE, 0, 0);
        step(200, 0, 1, 1, 24'h0, 24'h0, 0, 0);
        rstep(24'hE75A10, 24'hFEFEFE, 0, 0);
        step(600, 1, 0, 0, 24'h0, 24'h0, 0, 0);
        rstep(24'($urandom), rnd_mario(), 0, 0);
        step(1023, 1, 0, 0, 24'h0, 24'h0, 0, 0);
        rstep(24'($urandom), rnd_mario(), 0, 0);

        // Random pixels, random frame_clk, no death
        for (int i = 0; i < 200; i++) rstep(24'($urandom), rnd_mario(), 1'($urandom), 1'b0);

        // Full death sequence on a mostly-white background, with stray dead pulses along the way
        exp_dr = dr_seen;
        step(10, 1, 1, 0, 24'hFEFEFE, 24'h0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            bit dd;
            dd = (i > 100 && i < 240 && ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 3) == 0)
                rstep(24'($urandom), rnd_mario(), ((cyc % 4) < 2), dd);
            else
                step($urandom_range(0, 1023), 1, 1, 0, 24'hFEFEFE, 24'hFEFEFE, ((cyc % 4) < 2), dd);
        end
        for (int i = 0; i < 3; i++) rstep(24'hFEFEFE, rnd_mario(), 0, 0);
        total++;
        if (dr_seen - exp_dr != 1) begin
            bad++;
            $display("FAIL dead_reset_count got=%0d exp=1", dr_seen - exp_dr);
        end

        // Reset mid fade-out at level 3, then full brightness with no dead_reset
        step(10, 1, 1, 0, 24'hFEFEFE, 24'h0, 0, 1);
        for (int i = 0; i < 200 && !(active && n >= 13); i++)
            step(50, 1, 1, 0, 24'hFEFEFE, 24'h0, ((cyc % 4) < 2), 0);
        exp_dr = dr_seen;
        rst_req = 0;
        for (int i = 0; i < 4; i++) rstep(24'($urandom), rnd_mario(), 1'($urandom), 1'($urandom));
        rst_req = 1;
        for (int i = 0; i < 120; i++)
            step(50, 1, 1, 0, 24'hFEFEFE, 24'h0, ((cyc % 4) < 2), 0);
        total++;
        if (dr_seen != exp_dr) begin
            bad++;
            $display("FAIL dead_reset_after_reset got=%0d exp=0", dr_seen - exp_dr);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
